rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised successor to the 2:1/4:1 mux tree: an N-input, WIDTH-bit registered multiplexer with its own arbitration.
- The select is derived internally by a round-robin or fixed-priority arbiter over per-channel valid/ready handshakes.
- The selected word is held in one output pipeline register with valid/ready backpressure.
- Used wherever several producers share one datapath bus, for example writeback or memory-request sharing.

Parameters:
- WIDTH, 16: data width per channel, in bits.
- N, 4: number of input channels; must be a power of 2 in the range 2..16.
- SEL_W, log2(N): width of the select and pointer; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that produced out_data.
- out_valid  output  1  out_data and out_sel are valid.
- out_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready=0 for as long as rst is held.
  - Any pending output is discarded; there is no replay after reset.
- Load condition: load = (|in_valid) && (!out_valid || out_ready).
  - This gives full throughput: one transfer per cycle when out_ready is held at 1.
- Grant (combinational, from the current in_valid, mode and ptr):
  - Round-robin: first valid index searching ptr, ptr+1, ..., wrapping mod N.
  - Fixed: lowest valid index; ptr is ignored.
  - in_ready[i] = load && grant[i]; at most one bit set.
  - in_ready must not depend on in_data.
- On load (registered):
  - out_data <= in_data of the granted channel.
  - out_sel <= granted index; out_valid <= 1.
  - ptr <= (granted index + 1) mod N, in both modes, so a mode switch is well defined.
- No load, out_valid && out_ready: out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready):
  - out_data, out_sel, out_valid and ptr are all held.
  - in_ready = 0.
- Simultaneous out_ready=1 and a new request in the same cycle: the new word replaces the old one in that cycle with no bubble.
- Latency: 1 cycle from the in_valid&&in_ready handshake to out_valid.
- Wrap-around: with ptr=N-1 and only channel 0 valid, channel 0 is granted and ptr becomes 1.
- mode is sampled only via the combinational grant; a change takes effect at the next load and does not affect a word already held.
- in_valid dropping while not granted is legal; there is no request latching.
- Data stability: out_data changes only on load or reset.

Decomposition:
- Shared include file arb_defs.vh holds:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - The clog2 helper function used to compute SEL_W.
- One sub-module, rr_grant (parameter N): combinational.
  - Inputs: req, ptr, mode.
  - Outputs: one-hot grant, encoded index, any_req.
  - Implementation: rotate-by-ptr, priority-encode, rotate back.
- The output register and pointer stay in rr_arb_mux.
- The data select is a flat N:1 WIDTH-bit mux indexed by the encoded grant.

Test Plan (N=4, WIDTH=16, channel i data = 16'hA000+i):
- Reset mid-transfer: out_valid=1, assert rst asynchronously between edges → out_valid=0, out_data=0, out_sel=0 immediately; the first grant after release is channel 0.
- RR full load: mode=0, in_valid=4'b1111, out_ready=1 → in_ready cycles 0001,0010,0100,1000,0001; out_sel 0,1,2,3,0 one cycle later; out_data A000..A003.
- Backpressure: out_valid=1 with out_sel=1, out_ready=0 for 3 cycles → out_data=A001 stable, in_ready=0000, ptr=2; on release with all valid, next out_sel=2.
- Wrap: after a channel-2 grant (ptr=3), in_valid=4'b0011 → grant channel 0, then channel 1; channel 3 is skipped without a stall.
- Fixed mode: mode=1, in_valid=4'b1010, out_ready=1 for 4 cycles → out_sel=1 every cycle; switch to mode=0 → next grant is channel 3 (ptr=2).
- Idle drain: in_valid=0000 with out_valid=1, out_ready=1 → out_valid=0 next cycle, out_data holds its value, ptr unchanged.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared definitions for the arbitrated output mux.
//   MODE_RR / MODE_FIXED : encodings of the 'mode' input.
//   clog2()              : elaboration-time log2 used to size select/pointer.
package rr_arb_mux_pkg;

  localparam logic MODE_RR    = 1'b0;  // round-robin, search starts at ptr
  localparam logic MODE_FIXED = 1'b1;  // fixed priority, lowest index wins

  // Smallest r with 2**r >= value. Only meaningful for value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_grant.sv
// rr_grant: combinational request arbiter.
//   req_i     [N-1:0]     per-channel requests
//   ptr_i     [SEL_W-1:0] round-robin start index (ignored in fixed mode)
//   mode_i                MODE_RR or MODE_FIXED
//   grant_o   [N-1:0]     one-hot grant, zero when no request
//   idx_o     [SEL_W-1:0] encoded index of the granted channel
//   any_req_o             at least one request present
// Method: rotate requests right by the start index so the search always
// begins at bit 0, priority-encode the lowest set bit, then rotate the
// result back. N is a power of two, so SEL_W-bit addition wraps mod N.
module rr_grant
  import rr_arb_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [N-1:0]     grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_req_o
);

  logic [SEL_W-1:0] eff_ptr;
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     grant_rot;
  logic [2*N-1:0]   grant_dbl;
  logic [SEL_W-1:0] idx_rot;
  logic             found;

  // Fixed priority is just round-robin with the start index pinned to 0.
  assign eff_ptr   = (mode_i == MODE_FIXED) ? '0 : ptr_i;
  assign req_dbl   = {req_i, req_i} >> eff_ptr;
  assign req_rot   = req_dbl[N-1:0];
  assign any_req_o = |req_i;

  always_comb begin
    idx_rot   = '0;
    grant_rot = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        idx_rot      = SEL_W'(i);
        grant_rot[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Rotate back: the upper half of the doubled vector is the left rotation.
  assign grant_dbl = {grant_rot, grant_rot} << eff_ptr;
  assign grant_o   = grant_dbl[2*N-1:N];
  assign idx_o     = idx_rot + eff_ptr;

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input, WIDTH-bit arbitrated mux with one output register.
//   clk, rst          clock; asynchronous active-high reset
//   mode              0 = round-robin, 1 = fixed priority (lowest wins)
//   in_data [N*W-1:0] channel i at [i*WIDTH +: WIDTH]
//   in_valid[N-1:0]   per-channel request
//   in_ready[N-1:0]   per-channel accept, one-hot or zero
//   out_data/out_sel  registered word and the index that produced it
//   out_valid         out_data/out_sel hold a word
//   out_ready         consumer takes the word this cycle
// Handshake: a transfer happens on a rising edge where valid && ready on
// the same side; valid never waits on ready. The output stage accepts a new
// word whenever it is empty or being drained in the same cycle, so a held
// out_ready gives one word per cycle with no bubble.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,   // power of two, 2..16
  localparam int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q,  sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q,  ptr_d;

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             any_req;
  logic             load;

  rr_grant #(.N(N)) u_grant (
    .req_i     (in_valid),
    .ptr_i     (ptr_q),
    .mode_i    (mode),
    .grant_o   (grant),
    .idx_o     (grant_idx),
    .any_req_o (any_req)
  );

  assign load = any_req && (!valid_q || out_ready);

  // rst is gated in directly so no channel sees an accept while reset is
  // held, even though the registers are already cleared.
  assign in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      data_d  = in_data[grant_idx*WIDTH +: WIDTH];
      sel_d   = grant_idx;
      valid_d = 1'b1;
      // Advanced in both modes so switching to round-robin resumes just
      // past the last winner.
      ptr_d   = grant_idx + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  localparam int WIDTH = 16;
  localparam int N     = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               mode;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set inputs, let the combinational grant settle, check in_ready.
  task automatic drive(input logic m, input logic [N-1:0] v, input logic rdy,
                       input logic [N-1:0] exp_ready, input string tag);
    mode      = m;
    in_valid  = v;
    out_ready = rdy;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
  endtask

  task automatic expect_out(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                            input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_sel"},   32'(out_sel),   32'(s));
    chk({tag, "_data"},  32'(out_data),  32'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mode      = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);

    // Reset held: registers cleared, no accepts even with requests pending.
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 4'b1111, 1'b1, 4'b0000, "rst_held");
    expect_out(1'b0, 2'd0, 16'h0000, "rst_held");
    rst = 1'b0;
    #1;

    // Round-robin full load: grants 0,1,2,3,0; word visible one cycle later.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, 1'b1, 4'(1 << (k % 4)), "rr_full");
      exp_q.push_back(16'hA000 + 16'(k % 4));
      tick();
      chk("rr_full_valid", 32'(out_valid), 32'd1);
      chk("rr_full_sel",   32'(out_sel),   32'(k % 4));
      chk("rr_full_data",  32'(out_data),  32'(exp_q.pop_front()));
    end
    // ptr = 1 now: next grant is channel 1.
    drive(1'b0, 4'b1111, 1'b1, 4'b0010, "bp_setup");
    tick();
    expect_out(1'b1, 2'd1, 16'hA001, "bp_setup");

    // Backpressure for 3 cycles: everything holds, no accepts.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b1111, 1'b0, 4'b0000, "bp_stall");
      tick();
      expect_out(1'b1, 2'd1, 16'hA001, "bp_stall");
    end
    // Release: ptr stayed at 2.
    drive(1'b0, 4'b1111, 1'b1, 4'b0100, "bp_release");
    tick();
    expect_out(1'b1, 2'd2, 16'hA002, "bp_release");

    // Wrap: ptr = 3, only 0 and 1 requesting -> 0 then 1, no stall.
    drive(1'b0, 4'b0011, 1'b1, 4'b0001, "wrap0");
    tick();
    expect_out(1'b1, 2'd0, 16'hA000, "wrap0");
    drive(1'b0, 4'b0011, 1'b1, 4'b0010, "wrap1");
    tick();
    expect_out(1'b1, 2'd1, 16'hA001, "wrap1");

    // Fixed priority: channel 1 wins every cycle over channel 3.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b1010, 1'b1, 4'b0010, "fixed");
      tick();
      expect_out(1'b1, 2'd1, 16'hA001, "fixed");
    end
    // Back to round-robin: ptr = 2, so channel 3 is next.
    drive(1'b0, 4'b1010, 1'b1, 4'b1000, "mode_switch");
    tick();
    expect_out(1'b1, 2'd3, 16'hA003, "mode_switch");

    // Idle drain: valid drops, data and select hold.
    drive(1'b0, 4'b0000, 1'b1, 4'b0000, "drain");
    tick();
    expect_out(1'b0, 2'd3, 16'hA003, "drain");
    tick();
    expect_out(1'b0, 2'd3, 16'hA003, "drain_hold");

    // Load into an empty stage with out_ready low; ptr = 0 so channel 2
    // wins only because it is the sole requester. The next cycle stalls.
    drive(1'b0, 4'b0100, 1'b0, 4'b0100, "empty_load");
    tick();
    expect_out(1'b1, 2'd2, 16'hA002, "empty_load");
    drive(1'b0, 4'b1111, 1'b0, 4'b0000, "empty_stall");
    tick();
    expect_out(1'b1, 2'd2, 16'hA002, "empty_stall");

    // Reset mid-transfer, asserted between edges: clears immediately.
    #3;
    rst = 1'b1;
    #1;
    expect_out(1'b0, 2'd0, 16'h0000, "rst_async");
    chk("rst_async_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // ptr was 3 before reset; after release the first grant is channel 0.
    drive(1'b0, 4'b1111, 1'b1, 4'b0001, "post_rst");
    tick();
    expect_out(1'b1, 2'd0, 16'hA000, "post_rst");

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
